// File: rtl/board_editor_pkg.sv
// Shared types and helpers for the board editor.
// Holds the editor state encoding, the cursor-width helper and the cell index helper.
// Imported by the top level; has no ports.
package board_editor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        CLEAR,
        HOLD
    } state_t;

    localparam int DEFAULT_ROWS = 16;
    localparam int DEFAULT_COLS = 16;

    // Cursor width for a given row count; never narrower than one bit.
    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Flat board bit position of cell (r, c).
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/board_editor_btn_edge.sv
// Button conditioner: 2-flop synchroniser, delay flop and registered rising-edge pulse.
// Ports: clk, rst_n (async active-low), btn (raw input), pulse (one-cycle strobe per press).
// Latency: pulse is high in the cycle following the 3rd rising clk after btn is first sampled high.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            s3    <= s2;
            // Registered so the owning FSM acts on the 3rd edge after first sample.
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/board_editor.sv
// Board editor: operator builds a ROWS x COLS board from switches and buttons, then hands it off.
// Ports: clk, rst_n, enable, btn_up/down/load/clear/start, sw -> cursor_row, board, busy, done.
// All outputs registered; button pulses arriving in a state that does not use them are dropped.
module board_editor
    import board_editor_pkg::*;
#(
    parameter int ROWS  = DEFAULT_ROWS,
    parameter int COLS  = DEFAULT_COLS,
    parameter int WRAP  = 0,
    parameter int ROW_W = row_width(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_load,
    input  logic                 btn_clear,
    input  logic                 btn_start,
    input  logic [COLS-1:0]      sw,
    output logic [ROW_W-1:0]     cursor_row,
    output logic [ROWS*COLS-1:0] board,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ROW_W:0]   LAST_EXT = (ROW_W+1)'(ROWS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic p_up;
    logic p_down;
    logic p_load;
    logic p_clear;
    logic p_start;

    btn_edge u_up    (.clk(clk), .rst_n(rst_n), .btn(btn_up),    .pulse(p_up));
    btn_edge u_down  (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .pulse(p_down));
    btn_edge u_load  (.clk(clk), .rst_n(rst_n), .btn(btn_load),  .pulse(p_load));
    btn_edge u_clear (.clk(clk), .rst_n(rst_n), .btn(btn_clear), .pulse(p_clear));
    btn_edge u_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(p_start));

    state_t                 state;
    logic [ROW_W-1:0]       cursor_q;
    logic [ROW_W-1:0]       clr_row;
    logic [ROWS*COLS-1:0]   board_q;
    logic                   busy_q;
    logic                   done_q;
    logic [ROW_W-1:0]       next_row;

    // Cursor move computed one bit wider so ROWS that are not a power of two
    // still compare cleanly against the last row.
    always_comb begin
        logic [ROW_W:0] cur_ext;
        logic [ROW_W:0] nxt;
        cur_ext = {1'b0, cursor_q};
        nxt     = cur_ext;
        if (p_up && !p_down) begin
            if (cur_ext == '0) begin
                nxt = (WRAP != 0) ? LAST_EXT : '0;
            end else begin
                nxt = cur_ext - (ROW_W+1)'(1);
            end
        end else if (p_down && !p_up) begin
            if (cur_ext == LAST_EXT) begin
                nxt = (WRAP != 0) ? '0 : LAST_EXT;
            end else begin
                nxt = cur_ext + (ROW_W+1)'(1);
            end
        end
        next_row = nxt[ROW_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cursor_q <= '0;
            clr_row  <= '0;
            board_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && !enable) begin
                // Abandon whatever is in progress; board content is kept as-is.
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state    <= EDIT;
                            cursor_q <= '0;
                        end
                    end
                    EDIT: begin
                        if (p_start) begin
                            state  <= HOLD;
                            done_q <= 1'b1;
                        end else if (p_clear) begin
                            state   <= CLEAR;
                            busy_q  <= 1'b1;
                            clr_row <= '0;
                        end else begin
                            // Load targets the row the cursor is on before this cycle's move.
                            if (p_load) begin
                                board_q[cell_idx(int'(cursor_q), 0, COLS) +: COLS] <= sw;
                            end
                            cursor_q <= next_row;
                        end
                    end
                    CLEAR: begin
                        board_q[cell_idx(int'(clr_row), 0, COLS) +: COLS] <= '0;
                        if (clr_row == LAST_ROW) begin
                            state  <= EDIT;
                            busy_q <= 1'b0;
                        end else begin
                            clr_row <= clr_row + ROW_W'(1);
                        end
                    end
                    HOLD: begin
                        // Board and cursor frozen until enable drops.
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cursor_row = cursor_q;
    assign board      = board_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_board_editor.sv
// Bench for board_editor: three instances (16x16 saturate, 16x16 wrap, 10x8 saturate)
// share buttons, enable and reset, and are compared against a press-level reference model.
module tb_board_editor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         btn_up, btn_down, btn_load, btn_clear, btn_start;
    logic [15:0]  sw;

    logic [3:0]   cur0, cur1, cur2;
    logic [255:0] brd0, brd1;
    logic [79:0]  brd2;
    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance rows, cursor and mode (0 idle, 1 edit, 2 hold).
    logic [15:0] mboard [3][16];
    int          mcur   [3];
    int          mmode  [3];

    always #5 clk = ~clk;

    board_editor #(.ROWS(16), .COLS(16), .WRAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .btn_up(btn_up), .btn_down(btn_down),
        .btn_load(btn_load), .btn_clear(btn_clear), .btn_start(btn_start), .sw(sw),
        .cursor_row(cur0), .board(brd0), .busy(busy0), .done(done0));

    board_editor #(.ROWS(16), .COLS(16), .WRAP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .btn_up(btn_up), .btn_down(btn_down),
        .btn_load(btn_load), .btn_clear(btn_clear), .btn_start(btn_start), .sw(sw),
        .cursor_row(cur1), .board(brd1), .busy(busy1), .done(done1));

    board_editor #(.ROWS(10), .COLS(8), .WRAP(0)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .btn_up(btn_up), .btn_down(btn_down),
        .btn_load(btn_load), .btn_clear(btn_clear), .btn_start(btn_start), .sw(sw[7:0]),
        .cursor_row(cur2), .board(brd2), .busy(busy2), .done(done2));

    function automatic int nrows(input int i);
        return (i == 2) ? 10 : 16;
    endfunction

    function automatic int ncols(input int i);
        return (i == 2) ? 8 : 16;
    endfunction

    function automatic logic [255:0] exp_board(input int i);
        logic [255:0] v;
        v = '0;
        for (int r = 0; r < nrows(i); r++)
            for (int c = 0; c < ncols(i); c++)
                v[r*ncols(i)+c] = mboard[i][r][c];
        return v;
    endfunction

    function automatic logic [255:0] dut_board(input int i);
        case (i)
            0:       return brd0;
            1:       return brd1;
            default: return {176'b0, brd2};
        endcase
    endfunction

    function automatic int dut_cursor(input int i);
        case (i)
            0:       return int'(cur0);
            1:       return int'(cur1);
            default: return int'(cur2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 16; r++) mboard[i][r] = '0;
            mcur[i]  = 0;
            mmode[i] = 0;
        end
    endtask

    task automatic model_press(input logic up, input logic down, input logic load,
                               input logic clr, input logic st);
        for (int i = 0; i < 3; i++) begin
            if (mmode[i] == 1) begin
                if (st) begin
                    mmode[i] = 2;
                end else if (clr) begin
                    for (int r = 0; r < 16; r++) mboard[i][r] = '0;
                end else begin
                    if (load) mboard[i][mcur[i]] = (i == 2) ? {8'h00, sw[7:0]} : sw;
                    if (up && !down)
                        mcur[i] = (mcur[i] == 0) ? ((i == 1) ? nrows(i) - 1 : 0) : mcur[i] - 1;
                    else if (down && !up)
                        mcur[i] = (mcur[i] == nrows(i) - 1) ? ((i == 1) ? 0 : mcur[i]) : mcur[i] + 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic down, input logic load,
                         input logic clr, input logic st);
        int hold;
        hold = $urandom_range(1, 4);
        btn_up = up; btn_down = down; btn_load = load; btn_clear = clr; btn_start = st;
        repeat (hold) step();
        btn_up = 0; btn_down = 0; btn_load = 0; btn_clear = 0; btn_start = 0;
        repeat (24) step();
        model_press(up, down, load, clr, st);
    endtask

    task automatic enable_cycle();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            mmode[i] = 1;
            mcur[i]  = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; sw = '0;
        btn_up = 0; btn_down = 0; btn_load = 0; btn_clear = 0; btn_start = 0;
        model_reset();
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_board(i) !== '0 || dut_cursor(i) !== 0) begin
                errors++;
                $display("FAIL reset_state inst%0d: board=%h cursor=%0d required board=0 cursor=0",
                         i, dut_board(i), dut_cursor(i));
            end
        end
        checks++;
        if ({busy0, busy1, busy2, done0, done1, done2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/done=%b required 000000",
                     {busy0, busy1, busy2, done0, done1, done2});
        end
        #2 rst_n = 1;
        repeat (2) step();
        enable = 1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) mmode[i] = 1;
    endtask

    task automatic test_load_row();
        sw = 16'hA5A5;
        btn_load = 1;
        repeat (3) step();
        checks++;
        if (brd0[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL load_early: row0=%h after 3 edges, required 0000", brd0[15:0]);
        end
        step();
        checks++;
        if (brd0[15:0] !== 16'hA5A5 || brd0[255:16] !== '0 || cur0 !== 4'd0) begin
            errors++;
            $display("FAIL load_row0: row0=%h rest_nonzero=%b cursor=%0d required A5A5/0/0",
                     brd0[15:0], |brd0[255:16], cur0);
        end
        sw = 16'h1234;
        step();
        btn_load = 0;
        repeat (20) step();
        checks++;
        if (brd0[15:0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL load_once: row0=%h after long hold, required A5A5", brd0[15:0]);
        end
        sw = 16'hA5A5;
        model_press(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_board(i) !== exp_board(i)) begin
                errors++;
                $display("FAIL load_model inst%0d: board=%h required %h", i, dut_board(i), exp_board(i));
            end
        end
    endtask

    task automatic test_move();
        enable_cycle();
        repeat (20) press(0, 1, 0, 0, 0);
        checks++;
        if (cur0 !== 4'd15 || cur2 !== 4'd9 || dut_cursor(1) !== mcur[1]) begin
            errors++;
            $display("FAIL move_saturate: cursors=%0d/%0d/%0d required 15/%0d/9", cur0, cur1, cur2, mcur[1]);
        end
        sw = 16'($urandom);
        press(0, 0, 1, 0, 0);
        checks++;
        if (brd2[79:72] !== sw[7:0]) begin
            errors++;
            $display("FAIL row9_bits: board[79:72]=%h required %h", brd2[79:72], sw[7:0]);
        end
        press(1, 0, 0, 0, 0);
        checks++;
        if (cur0 !== 4'd14) begin
            errors++;
            $display("FAIL move_up: cursor=%0d required 14", cur0);
        end
    endtask

    task automatic test_wrap();
        enable_cycle();
        press(1, 0, 0, 0, 0);
        checks++;
        if (cur1 !== 4'd15 || cur0 !== 4'd0 || cur2 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_up: cursors=%0d/%0d/%0d required 0/15/0", cur0, cur1, cur2);
        end
        press(0, 1, 0, 0, 0);
        checks++;
        if (cur1 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_down: cursor=%0d required 0", cur1);
        end
    endtask

    task automatic test_load_move();
        enable_cycle();
        repeat (3) press(0, 1, 0, 0, 0);
        sw = 16'h00FF;
        press(0, 1, 1, 0, 0);
        checks++;
        if (brd0[63:48] !== 16'h00FF || cur0 !== 4'd4) begin
            errors++;
            $display("FAIL load_move: row3=%h cursor=%0d required 00FF/4", brd0[63:48], cur0);
        end
        press(1, 1, 0, 0, 0);
        checks++;
        if (cur0 !== 4'd4) begin
            errors++;
            $display("FAIL up_down_together: cursor=%0d required 4", cur0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_board(i) !== exp_board(i) || dut_cursor(i) !== mcur[i]) begin
                errors++;
                $display("FAIL load_move_model inst%0d: cursor=%0d required %0d", i, dut_cursor(i), mcur[i]);
            end
        end
    endtask

    task automatic fill_all();
        enable_cycle();
        sw = 16'hFFFF;
        repeat (16) press(0, 1, 1, 0, 0);
    endtask

    task automatic test_clear();
        int b0;
        int b2;
        b0 = 0; b2 = 0;
        fill_all();
        for (int k = 0; k < 40; k++) begin
            btn_clear = (k < 2);
            btn_load  = (k == 5);
            step();
            if (busy0) b0++;
            if (busy2) b2++;
        end
        btn_clear = 0; btn_load = 0;
        model_press(0, 0, 0, 1, 0);
        checks++;
        if (b0 !== 16 || b2 !== 10) begin
            errors++;
            $display("FAIL clear_busy_len: busy cycles=%0d/%0d required 16/10", b0, b2);
        end
        checks++;
        if (brd0 !== '0 || brd2 !== '0 || cur0 !== 4'(mcur[0])) begin
            errors++;
            $display("FAIL clear_result: board0_nonzero=%b board2_nonzero=%b cursor=%0d required 0/0/%0d",
                     |brd0, |brd2, cur0, mcur[0]);
        end
    endtask

    task automatic test_start();
        int d0;
        int d1;
        int d2;
        d0 = 0; d1 = 0; d2 = 0;
        enable_cycle();
        sw = 16'($urandom);
        press(0, 1, 1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            btn_start = (k < 3);
            step();
            if (done0) d0++;
            if (done1) d1++;
            if (done2) d2++;
        end
        btn_start = 0;
        model_press(0, 0, 0, 0, 1);
        checks++;
        if (d0 !== 1 || d1 !== 1 || d2 !== 1) begin
            errors++;
            $display("FAIL done_strobe: done cycles=%0d/%0d/%0d required 1/1/1", d0, d1, d2);
        end
        sw = ~sw;
        press(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_board(i) !== exp_board(i) || dut_cursor(i) !== mcur[i]) begin
                errors++;
                $display("FAIL hold_frozen inst%0d: cursor=%0d required %0d", i, dut_cursor(i), mcur[i]);
            end
        end
        enable_cycle();
        checks++;
        if (cur0 !== 4'd0 || cur1 !== 4'd0 || cur2 !== 4'd0) begin
            errors++;
            $display("FAIL reenter_edit: cursors=%0d/%0d/%0d required 0/0/0", cur0, cur1, cur2);
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 99);
            sw = 16'($urandom);
            if (r < 5)       press(0, 0, 0, 0, 1);
            else if (r < 10) press(0, 0, 0, 1, 0);
            else if (r < 18) enable_cycle();
            else             press(1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_board(i) !== exp_board(i) || dut_cursor(i) !== mcur[i]) begin
                    errors++;
                    $display("FAIL random_%0d inst%0d: cursor=%0d required %0d board=%h required %h",
                             n, i, dut_cursor(i), mcur[i], dut_board(i), exp_board(i));
                end
            end
        end
    endtask

    task automatic test_interrupted_clear();
        int m;
        m = 0;
        fill_all();
        for (int k = 0; k < 40 && m < 5; k++) begin
            btn_clear = (k < 2);
            step();
            if (busy0) m++;
        end
        btn_clear = 0;
        checks++;
        if (m !== 5) begin
            errors++;
            $display("FAIL clear_start_timeout: busy samples=%0d required 5", m);
        end
        enable = 0;
        repeat (3) step();
        checks++;
        if (busy0 !== 1'b0 || brd0[63:0] !== 64'h0 || brd0[255:80] !== {11{16'hFFFF}}) begin
            errors++;
            $display("FAIL interrupted_clear: busy=%b rows0-3=%h rows5-15=%h required 0/0/all ones",
                     busy0, brd0[63:0], brd0[255:80]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int seen;
        seen = 0;
        fill_all();
        for (int k = 0; k < 40 && seen == 0; k++) begin
            btn_clear = (k < 2);
            step();
            if (busy0) seen = 1;
        end
        btn_clear = 0;
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (seen !== 1 || brd0 !== '0 || brd1 !== '0 || brd2 !== '0 || busy0 !== 1'b0 ||
            done0 !== 1'b0 || cur0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: seen=%0d busy=%b board_nonzero=%b cursor=%0d required 1/0/0/0",
                     seen, busy0, |{brd0, brd1, brd2}, cur0);
        end
        enable = 0;
        repeat (2) step();
        #2 rst_n = 1;
        sw = 16'hFFFF;
        press(0, 1, 1, 0, 0);
        checks++;
        if (brd0 !== '0 || cur0 !== 4'd0) begin
            errors++;
            $display("FAIL idle_ignores: board_nonzero=%b cursor=%0d required 0/0", |brd0, cur0);
        end
        enable = 1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) mmode[i] = 1;
        press(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_board(i) !== exp_board(i)) begin
                errors++;
                $display("FAIL after_reset_load inst%0d: board=%h required %h", i, dut_board(i), exp_board(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_row();
        test_move();
        test_wrap();
        test_load_move();
        test_clear();
        test_start();
        test_random();
        test_interrupted_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
